// File: rtl/neuron_accumulator.sv
// neuron_accumulator: multi-lane accumulation of a snapshot channel vector.
//
// A start in IDLE snapshots the NEURONS input channels and walks through
// them LANES at a time, adding each beat's lane sum into a running
// accumulator. After the last beat the accumulator window
// acc[SHIFT+OUT_W-1:SHIFT] is registered onto res and done pulses for one
// cycle. Without clear, consecutive passes keep adding onto the same acc.
//
// Build option: define NEURON_ACC_SAT_EN to make acc clamp at its maximum
// and res clamp at 2^OUT_W-1. The default build wraps and truncates.
module neuron_accumulator #(
    parameter int NEURONS = 8,
    parameter int DATA_W  = 8,
    parameter int LANES   = 2,
    parameter int ACC_W   = 14,
    parameter int SHIFT   = 4,
    parameter int OUT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] a [0:NEURONS-1],
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  res
);

    localparam int BEATS  = (NEURONS + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Lane sum is kept wide enough that LANES full-scale channels never overflow
    localparam int LSUM_W = DATA_W + $clog2(LANES + 1);
    // One extra bit above the wider operand exposes the carry for clamping
    localparam int SUM_W  = ((ACC_W > LSUM_W) ? ACC_W : LSUM_W) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [BEAT_W-1:0] beat;
    logic [DATA_W-1:0] snap [0:NEURONS-1];
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [LSUM_W-1:0] lane_sum;
    logic [SUM_W-1:0]  sum;
    logic [OUT_W-1:0]  res_next;
    logic              last_beat;
    int                base;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // Sum the snapshot channels owned by the current beat; channels past the end contribute nothing
    always_comb begin
        lane_sum = '0;
        base     = int'(beat) * LANES;
        for (int n = 0; n < NEURONS; n++) begin
            if (n >= base && n < base + LANES) begin
                lane_sum = lane_sum + LSUM_W'(snap[n]);
            end
        end
    end

    // Next accumulator value and the output window it would produce
    always_comb begin
        sum = SUM_W'(acc) + SUM_W'(lane_sum);
`ifdef NEURON_ACC_SAT_EN
        acc_next = (|(sum >> ACC_W)) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        res_next = (|(acc_next >> (SHIFT + OUT_W))) ? {OUT_W{1'b1}}
                                                    : acc_next[SHIFT+OUT_W-1:SHIFT];
`else
        acc_next = sum[ACC_W-1:0];
        res_next = acc_next[SHIFT+OUT_W-1:SHIFT];
`endif
    end

    // Control FSM, snapshot, beat counter, accumulator and output register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
            acc   <= '0;
            res   <= '0;
            for (int n = 0; n < NEURONS; n++) begin
                snap[n] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        beat  <= '0;
                        for (int n = 0; n < NEURONS; n++) begin
                            snap[n] <= a[n];
                        end
                        if (clear) begin
                            acc <= '0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (last_beat) begin
                        state <= DONE;
                        res   <= res_next;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: randomized, self-checking bench for neuron_accumulator.
// The reference model tracks the accumulator as a plain integer sum of whole
// passes and derives res from it arithmetically. Honours NEURON_ACC_SAT_EN.
module tb_neuron_accumulator;

    localparam int NEURONS = 8;
    localparam int DATA_W  = 8;
    localparam int LANES   = 2;
    localparam int ACC_W   = 14;
    localparam int SHIFT   = 4;
    localparam int OUT_W   = 8;
    localparam int BEATS   = 4;
    localparam int BEATS2  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] a [0:NEURONS-1];
    logic       busy;
    logic       done;
    logic [7:0] res;

    logic       start2 = 1'b0;
    logic       clear2 = 1'b0;
    logic [7:0] a2 [0:4];
    logic       busy2;
    logic       done2;
    logic [7:0] res2;

    int     checks   = 0;
    int     failures = 0;
    longint model_acc = 0;

    // Free-running clock
    always #5 clock = ~clock;

    neuron_accumulator #(
        .NEURONS(NEURONS), .DATA_W(DATA_W), .LANES(LANES),
        .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .clear(clear),
        .a(a), .busy(busy), .done(done), .res(res)
    );

    neuron_accumulator #(
        .NEURONS(5), .DATA_W(8), .LANES(2),
        .ACC_W(14), .SHIFT(0), .OUT_W(8)
    ) dut2 (
        .clock(clock), .reset(reset), .start(start2), .clear(clear2),
        .a(a2), .busy(busy2), .done(done2), .res(res2)
    );

    function automatic longint model_limit(input longint v);
        longint lim;
        lim = (longint'(1) << ACC_W);
`ifdef NEURON_ACC_SAT_EN
        return (v > lim - 1) ? lim - 1 : v;
`else
        return v % lim;
`endif
    endfunction

    function automatic longint model_res(input longint acc_v);
        longint sh;
        longint omax;
        sh   = acc_v >> SHIFT;
        omax = (longint'(1) << OUT_W) - 1;
`ifdef NEURON_ACC_SAT_EN
        return (sh > omax) ? omax : sh;
`else
        return sh & omax;
`endif
    endfunction

    task automatic model_pass(input logic c);
        longint total;
        total = 0;
        foreach (a[i]) total += longint'(a[i]);
        if (c) model_acc = 0;
        model_acc = model_limit(model_acc + total);
    endtask

    task automatic fill_a(input int mode, input int value);
        foreach (a[i]) a[i] = (mode == 0) ? 8'(value) : 8'($urandom_range(0, 255));
    endtask

    // Drives one pass and reports when done was seen (edges after the accepting edge)
    task automatic run_pass(input logic c, input logic change_a, input int ping_n,
                            output int done_n, output int busy_cycles, output int done_count);
        done_n      = -1;
        busy_cycles = 0;
        done_count  = 0;
        @(negedge clock);
        start = 1'b1;
        clear = c;
        model_pass(c);
        @(negedge clock);
        start = 1'b0;
        clear = 1'b0;
        if (change_a) fill_a(1, 0);
        for (int n = 0; n < 40; n++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                if (done_n < 0) done_n = n;
            end
            if (!busy && n > 0) break;
            start = (n == ping_n);
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        clear = 1'b1;
        fill_a(0, 200);
        foreach (a2[i]) a2[i] = 8'd0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (res !== 8'd0) begin failures++; $display("[TB] FAIL reset_res: got %0d expected 0", res); end
        checks++;
        if (busy2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy2: got %b expected 0", busy2); end
        start = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        model_acc = 0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int dn, bc, dc;
        fill_a(0, 16);
        run_pass(1'b1, 1'b0, -1, dn, bc, dc);
        checks++;
        if (dn !== BEATS) begin failures++; $display("[TB] FAIL basic_done_edge: got %0d expected %0d", dn, BEATS); end
        checks++;
        if (bc !== BEATS + 1) begin failures++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", bc, BEATS + 1); end
        checks++;
        if (dc !== 1) begin failures++; $display("[TB] FAIL basic_done_count: got %0d expected 1", dc); end
        checks++;
        if (res !== 8'd8) begin failures++; $display("[TB] FAIL basic_res: got %0d expected 8", res); end
        run_pass(1'b0, 1'b0, -1, dn, bc, dc);
        checks++;
        if (res !== 8'd16) begin failures++; $display("[TB] FAIL basic_res_accum: got %0d expected 16", res); end
        fill_a(0, 99);
        repeat (3) @(negedge clock);
        checks++;
        if (res !== 8'd16) begin failures++; $display("[TB] FAIL basic_res_hold: got %0d expected 16", res); end
    endtask

    task automatic test_snapshot();
        int dn, bc, dc;
        fill_a(0, 255);
        run_pass(1'b1, 1'b1, -1, dn, bc, dc);
        checks++;
        if (res !== 8'd127) begin failures++; $display("[TB] FAIL snapshot_res: got %0d expected 127", res); end
    endtask

    task automatic test_accumulate();
        int dn, bc, dc;
        int exp_res;
        fill_a(0, 255);
        run_pass(1'b1, 1'b0, -1, dn, bc, dc);
        for (int p = 1; p < 9; p++) begin
            run_pass(1'b0, 1'b0, -1, dn, bc, dc);
            checks++;
            if (res !== 8'(model_res(model_acc))) begin
                failures++;
                $display("[TB] FAIL accum_pass%0d: got %0d expected %0d", p, res, model_res(model_acc));
            end
        end
`ifdef NEURON_ACC_SAT_EN
        exp_res = 255;
`else
        exp_res = 123;
`endif
        checks++;
        if (res !== 8'(exp_res)) begin failures++; $display("[TB] FAIL accum_nine: got %0d expected %0d", res, exp_res); end
    endtask

    task automatic test_ignore_start();
        int dn, bc, dc;
        fill_a(1, 0);
        run_pass(1'b1, 1'b0, 1, dn, bc, dc);
        checks++;
        if (dc !== 1) begin failures++; $display("[TB] FAIL ignore_run_done_count: got %0d expected 1", dc); end
        checks++;
        if (res !== 8'(model_res(model_acc))) begin failures++; $display("[TB] FAIL ignore_run_res: got %0d expected %0d", res, model_res(model_acc)); end
        fill_a(1, 0);
        run_pass(1'b0, 1'b0, BEATS, dn, bc, dc);
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_done_busy: got %b expected 0", busy); end
        checks++;
        if (res !== 8'(model_res(model_acc))) begin failures++; $display("[TB] FAIL ignore_done_res: got %0d expected %0d", res, model_res(model_acc)); end
    endtask

    task automatic test_clear_alone();
        int dn, bc, dc;
        fill_a(1, 0);
        run_pass(1'b1, 1'b0, -1, dn, bc, dc);
        clear = 1'b1;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL clear_alone_busy: got %b expected 0", busy); end
        fill_a(1, 0);
        run_pass(1'b0, 1'b0, -1, dn, bc, dc);
        checks++;
        if (res !== 8'(model_res(model_acc))) begin failures++; $display("[TB] FAIL clear_alone_res: got %0d expected %0d", res, model_res(model_acc)); end
    endtask

    task automatic test_reset_abort();
        int dn, bc, dc;
        int seen_done;
        fill_a(1, 0);
        @(negedge clock);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        start = 1'b0;
        clear = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++;
        if (res !== 8'd0) begin failures++; $display("[TB] FAIL abort_res: got %0d expected 0", res); end
        seen_done = 0;
        for (int n = 0; n < 6; n++) begin
            if (done) seen_done++;
            if (n == 1) reset = 1'b0;
            @(negedge clock);
        end
        checks++;
        if (seen_done !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
        model_acc = 0;
        fill_a(1, 0);
        run_pass(1'b0, 1'b0, -1, dn, bc, dc);
        checks++;
        if (res !== 8'(model_res(model_acc))) begin failures++; $display("[TB] FAIL abort_fresh_res: got %0d expected %0d", res, model_res(model_acc)); end
    endtask

    task automatic test_random();
        int dn, bc, dc;
        logic c;
        for (int p = 0; p < 12; p++) begin
            fill_a(1, 0);
            c = 1'($urandom_range(0, 1));
            run_pass(c, 1'($urandom_range(0, 1)), -1, dn, bc, dc);
            checks++;
            if (dn !== BEATS) begin failures++; $display("[TB] FAIL random_done_edge%0d: got %0d expected %0d", p, dn, BEATS); end
            checks++;
            if (res !== 8'(model_res(model_acc))) begin failures++; $display("[TB] FAIL random_res%0d: got %0d expected %0d", p, res, model_res(model_acc)); end
        end
    endtask

    task automatic test_partial();
        int dn;
        int dc;
        foreach (a2[i]) a2[i] = 8'(i + 1);
        @(negedge clock);
        start2 = 1'b1;
        clear2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        clear2 = 1'b0;
        dn = -1;
        dc = 0;
        for (int n = 0; n < 20; n++) begin
            if (done2) begin
                dc++;
                if (dn < 0) dn = n;
            end
            if (!busy2 && n > 0) break;
            @(negedge clock);
        end
        checks++;
        if (dn !== BEATS2) begin failures++; $display("[TB] FAIL partial_done_edge: got %0d expected %0d", dn, BEATS2); end
        checks++;
        if (dc !== 1) begin failures++; $display("[TB] FAIL partial_done_count: got %0d expected 1", dc); end
        checks++;
        if (res2 !== 8'd15) begin failures++; $display("[TB] FAIL partial_res: got %0d expected 15", res2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_accumulate();
        test_ignore_start();
        test_clear_alone();
        test_reset_abort();
        test_random();
        test_partial();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
